// File: rtl/ntt_result_reader.sv
// Drains the NTT output FIFO after a transform and unpacks each 32-bit word into an even/odd
// coefficient pair written to the result RAM. Optional running checksum: NTT_RDR_CHECKSUM_EN.
module ntt_result_reader #(
  parameter int N_COEF       = 256,
  parameter int DW           = 16,
  parameter int FIFO_LATENCY = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            rd_empty_i,
  input  logic [2*DW-1:0] rd_dat_i,
  output logic            rd_req_o,
  output logic            wr_en_o,
  output logic [7:0]      wr_addr_a_o,
  output logic [7:0]      wr_addr_b_o,
  output logic [DW-1:0]   wr_data_a_o,
  output logic [DW-1:0]   wr_data_b_o,
  output logic            busy_o,
  output logic            done_o
`ifdef NTT_RDR_CHECKSUM_EN
  ,
  output logic [DW-1:0]   checksum_o
`endif
);

  // state  | meaning
  // IDLE   | after reset, waiting for the first start
  // READ   | issuing FIFO reads until N_COEF/2 requests are out
  // DRAIN  | all reads issued, waiting for in-flight data to be written
  // DONE   | every coefficient written; holds until the next start
  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  localparam logic [7:0] N_WORDS = 8'(N_COEF / 2);

  state_t                  state_q, state_d;
  logic [7:0]              issued_q, issued_d;
  logic [7:0]              written_q, written_d;
  logic [FIFO_LATENCY-1:0] valid_sr_q;
  logic                    wr_en_q;
  logic [DW-1:0]           wr_data_a_q, wr_data_b_q;
  logic                    rd_req;
  logic                    clear_cnt;

  always_comb begin
    state_d   = state_q;
    clear_cnt = 1'b0;
    rd_req    = (state_q == S_READ) && !rd_empty_i && (issued_q < N_WORDS);
    issued_d  = rd_req  ? issued_q + 8'd1  : issued_q;
    written_d = wr_en_q ? written_q + 8'd1 : written_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d   = S_READ;
          clear_cnt = 1'b1;
          issued_d  = 8'd0;
          written_d = 8'd0;
        end
      end
      S_READ: begin
        if (issued_q == N_WORDS) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Look at the post-increment count so done rises right after the last write.
        if (written_d == N_WORDS) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      issued_q    <= '0;
      written_q   <= '0;
      valid_sr_q  <= '0;
      wr_en_q     <= 1'b0;
      wr_data_a_q <= '0;
      wr_data_b_q <= '0;
    end else begin
      state_q       <= state_d;
      issued_q      <= issued_d;
      written_q     <= written_d;
      valid_sr_q[0] <= rd_req;
      for (int i = 1; i < FIFO_LATENCY; i++) valid_sr_q[i] <= valid_sr_q[i-1];
      wr_en_q <= valid_sr_q[FIFO_LATENCY-1];
      if (valid_sr_q[FIFO_LATENCY-1]) begin
        wr_data_a_q <= rd_dat_i[DW-1:0];
        wr_data_b_q <= rd_dat_i[2*DW-1:DW];
      end
    end
  end

`ifdef NTT_RDR_CHECKSUM_EN
  logic [DW-1:0] checksum_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)          checksum_q <= '0;
    else if (clear_cnt) checksum_q <= '0;
    else if (wr_en_q)   checksum_q <= checksum_q + wr_data_a_q + wr_data_b_q;
  end

  assign checksum_o = checksum_q;
`endif

  assign rd_req_o    = rd_req;
  assign wr_en_o     = wr_en_q;
  assign wr_addr_a_o = {written_q[6:0], 1'b0};
  assign wr_addr_b_o = {written_q[6:0], 1'b1};
  assign wr_data_a_o = wr_data_a_q;
  assign wr_data_b_o = wr_data_b_q;
  assign busy_o      = (state_q == S_READ) || (state_q == S_DRAIN);
  assign done_o      = (state_q == S_DONE);

endmodule

// File: tb/tb_ntt_result_reader.sv
// Directed bench for ntt_result_reader: a behavioural FIFO feeds the reader and a monitor
// scores every request and write against the preloaded FIFO contents.
module tb_ntt_result_reader;

  logic        clk = 1'b0;
  logic        rst_i, start_i;
  logic        rd_empty;
  logic [31:0] rd_dat = '0;
  logic        rd_req_o, wr_en_o, busy_o, done_o;
  logic [7:0]  wr_addr_a_o, wr_addr_b_o;
  logic [15:0] wr_data_a_o, wr_data_b_o;
`ifdef NTT_RDR_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  always #5 clk = ~clk;

  ntt_result_reader dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .rd_empty_i  (rd_empty),
    .rd_dat_i    (rd_dat),
    .rd_req_o    (rd_req_o),
    .wr_en_o     (wr_en_o),
    .wr_addr_a_o (wr_addr_a_o),
    .wr_addr_b_o (wr_addr_b_o),
    .wr_data_a_o (wr_data_a_o),
    .wr_data_b_o (wr_data_b_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
`ifdef NTT_RDR_CHECKSUM_EN
    ,
    .checksum_o  (checksum)
`endif
  );

  // FIFO model: 128 preloaded words, one-cycle read latency
  logic [31:0] mem [0:255];
  int   rd_ptr = 0;
  logic fifo_clr = 1'b0, empty_force = 1'b0, starve_mode = 1'b0, tog = 1'b0;

  assign rd_empty = (rd_ptr >= 128) || empty_force || (starve_mode && tog);

  always @(posedge clk) begin
    if (fifo_clr) rd_ptr <= 0;
    else if (rd_req_o) begin
      rd_dat <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
    tog <= starve_mode ? ~tog : 1'b0;
  end

  // monitor, sampled 1 time unit after each rising edge
  logic mon_clr = 1'b0;
  int   req_cnt = 0, req_empty = 0, wcnt = 0, bad_wr = 0, lat_bad = 0;
  logic req_h1 = 1'b0, req_h2 = 1'b0;

  always begin
    @(posedge clk);
    #1;
    if (mon_clr) begin
      req_cnt = 0; req_empty = 0; wcnt = 0; bad_wr = 0; lat_bad = 0;
      req_h1 = 1'b0; req_h2 = 1'b0;
    end else if (rst_i) begin
      req_h1 = 1'b0; req_h2 = 1'b0;
    end else begin
      if (rd_req_o) begin
        req_cnt++;
        if (rd_empty) req_empty++;
      end
      if (wr_en_o !== req_h2) lat_bad++;
      if (wr_en_o) begin
        if (wcnt > 255 ||
            wr_addr_a_o !== 8'(2*wcnt) || wr_addr_b_o !== 8'(2*wcnt+1) ||
            wr_data_a_o !== mem[wcnt][15:0] || wr_data_b_o !== mem[wcnt][31:16])
          bad_wr++;
        wcnt++;
      end
      req_h2 = req_h1;
      req_h1 = rd_req_o;
    end
  end

  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start_i = 1'b1;
    @(negedge clk) start_i = 1'b0;
  endtask

  task automatic clear_env();
    @(negedge clk) begin fifo_clr = 1'b1; mon_clr = 1'b1; end
    @(negedge clk) begin fifo_clr = 1'b0; mon_clr = 1'b0; end
  endtask

  // called right after pulse_start; cycle 1 is the first cycle after start was sampled
  task automatic wait_done(input int budget, output int cyc);
    cyc = 1;
    while (!done_o && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  int cyc;

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = {16'(2*k+1), 16'(2*k)};
    rst_i   = 1'b1;
    start_i = 1'b1;

    // reset held with start high and a non-empty FIFO
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_rd_req", rd_req_o, 0);
      check("rst_wr_en",  wr_en_o,  0);
      check("rst_busy",   busy_o,   0);
      check("rst_done",   done_o,   0);
    end
    start_i = 1'b0;
    @(negedge clk) rst_i = 1'b0;
    check("idle_no_req", rd_req_o, 0);

    // full drain with an always-ready FIFO
    clear_env();
    pulse_start();
    check("drain_busy_c1", busy_o, 1);
    check("drain_req_c1", rd_req_o, 1);
    wait_done(400, cyc);
    check("drain_cycles", cyc, 131);
    check("drain_done", done_o, 1);
    check("drain_busy_end", busy_o, 0);
    check("drain_wr_en_end", wr_en_o, 0);
    check("drain_req_cnt", req_cnt, 128);
    check("drain_wcnt", wcnt, 128);
    check("drain_bad_wr", bad_wr, 0);
    check("drain_latency", lat_bad, 0);
    repeat (3) @(negedge clk);
    check("done_held", done_o, 1);
    check("done_no_req", rd_req_o, 0);

    // starved FIFO, plus a stray start mid-drain that must be ignored
    starve_mode = 1'b1;
    clear_env();
    pulse_start();
    repeat (20) @(negedge clk);
    pulse_start();
    wait_done(1000, cyc);
    check("starve_done", done_o, 1);
    check("starve_req_empty", req_empty, 0);
    check("starve_req_cnt", req_cnt, 128);
    check("starve_wcnt", wcnt, 128);
    check("starve_bad_wr", bad_wr, 0);
    check("starve_latency", lat_bad, 0);
    starve_mode = 1'b0;

    // FIFO empty forever
    empty_force = 1'b1;
    clear_env();
    pulse_start();
    repeat (50) @(negedge clk);
    check("empty_req_cnt", req_cnt, 0);
    check("empty_wcnt", wcnt, 0);
    check("empty_busy", busy_o, 1);
    check("empty_done", done_o, 0);
    rst_i = 1'b1;
    @(negedge clk) begin rst_i = 1'b0; empty_force = 1'b0; end

    // reset mid-drain after 40 writes, then a clean restart
    clear_env();
    pulse_start();
    cyc = 0;
    while (wcnt < 40 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("midrst_reached40", (wcnt >= 40), 1);
    rst_i = 1'b1;
    #1;
    check("midrst_rd_req", rd_req_o, 0);
    check("midrst_wr_en", wr_en_o, 0);
    check("midrst_busy", busy_o, 0);
    check("midrst_done", done_o, 0);
    check("midrst_addr_a", wr_addr_a_o, 0);
    check("midrst_data", {wr_data_b_o, wr_data_a_o}, 0);
    @(negedge clk) begin fifo_clr = 1'b1; mon_clr = 1'b1; end
    @(negedge clk) begin fifo_clr = 1'b0; mon_clr = 1'b0; rst_i = 1'b0; end
    pulse_start();
    wait_done(400, cyc);
    check("restart_cycles", cyc, 131);
    check("restart_wcnt", wcnt, 128);
    check("restart_bad_wr", bad_wr, 0);

`ifdef NTT_RDR_CHECKSUM_EN
    // 128 words of 0x0002_FFFF: each pair adds 0x10001, i.e. 1 mod 2^16
    for (int k = 0; k < 256; k++) mem[k] = 32'h0002_FFFF;
    clear_env();
    pulse_start();
    wait_done(400, cyc);
    check("csum_done", done_o, 1);
    check("csum_value", checksum, 32'h0080);
    check("csum_bad_wr", bad_wr, 0);
    empty_force = 1'b1;
    pulse_start();
    check("csum_cleared", checksum, 0);
    check("csum_done_cleared", done_o, 0);
    rst_i = 1'b1;
    @(negedge clk) begin rst_i = 1'b0; empty_force = 1'b0; end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
